// File: rtl/hdmi_cfg_seq_pkg.sv
// Shared types and the power-up register table for the HDMI transmitter
// configuration sequencer.
package hdmi_cfg_seq_pkg;

    typedef enum logic [2:0] {
        ST_WAIT,
        ST_REQ,
        ST_GAP,
        ST_DONE,
        ST_ERR
    } state_e;

    typedef struct packed {
        logic [7:0] reg_addr;
        logic [7:0] data;
    } cfg_entry_t;

    localparam int TABLE_LEN = 10;

    localparam cfg_entry_t INIT_TABLE [TABLE_LEN] = '{
        '{reg_addr: 8'h41, data: 8'h10},
        '{reg_addr: 8'h98, data: 8'h03},
        '{reg_addr: 8'h9A, data: 8'hE0},
        '{reg_addr: 8'h9C, data: 8'h30},
        '{reg_addr: 8'h9D, data: 8'h61},
        '{reg_addr: 8'hA2, data: 8'hA4},
        '{reg_addr: 8'hA3, data: 8'hA4},
        '{reg_addr: 8'hE0, data: 8'hD0},
        '{reg_addr: 8'hF9, data: 8'h00},
        '{reg_addr: 8'h15, data: 8'h00}
    };

    // Entries beyond the table read as zero so an oversized NUM_REGS stays benign.
    function automatic cfg_entry_t table_entry(input logic [3:0] i);
        cfg_entry_t e;
        e = '0;
        if (int'(i) < TABLE_LEN) begin
            e = INIT_TABLE[i];
        end
        return e;
    endfunction

endpackage

// File: rtl/hdmi_cfg_seq.sv
// Walks the init table after a power-up delay, issuing one I2C write per entry
// with bounded NACK retries, and reports completion or failure.
module hdmi_cfg_seq
    import hdmi_cfg_seq_pkg::*;
#(
    parameter int          NUM_REGS    = 10,
    parameter logic [7:0]  DEV_ADDR    = 8'h72,
    parameter logic [15:0] WAIT_CYCLES = 16'd4096,
    parameter int          MAX_RETRY   = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       wr_done,
    input  logic       wr_nack,
    output logic       wr_req,
    output logic [7:0] wr_dev,
    output logic [7:0] wr_reg,
    output logic [7:0] wr_data,
    output logic       busy,
    output logic       cfg_done,
    output logic       cfg_err,
    output logic [3:0] idx
);

    localparam int RW = $clog2(MAX_RETRY + 1);
    localparam logic [3:0]    LAST_IDX   = 4'(NUM_REGS - 1);
    localparam logic [15:0]   WAIT_LAST  = 16'(WAIT_CYCLES - 16'd1);
    localparam logic [RW-1:0] RETRY_LAST = RW'(MAX_RETRY - 1);

    state_e        state_q, state_d;
    logic [15:0]   cnt_q, cnt_d;
    logic [3:0]    idx_q, idx_d;
    logic [RW-1:0] retry_q, retry_d;
    logic          wr_req_q, wr_req_d;
    logic [7:0]    wr_dev_q, wr_dev_d;
    logic [7:0]    wr_reg_q, wr_reg_d;
    logic [7:0]    wr_data_q, wr_data_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    cfg_entry_t    entry_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_WAIT;
            cnt_q     <= '0;
            idx_q     <= '0;
            retry_q   <= '0;
            wr_req_q  <= 1'b0;
            wr_dev_q  <= 8'h00;
            wr_reg_q  <= 8'h00;
            wr_data_q <= 8'h00;
            busy_q    <= 1'b1;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            retry_q   <= retry_d;
            wr_req_q  <= wr_req_d;
            wr_dev_q  <= wr_dev_d;
            wr_reg_q  <= wr_reg_d;
            wr_data_q <= wr_data_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        retry_d = retry_q;

        unique case (state_q)
            ST_WAIT: begin
                if (cnt_q == WAIT_LAST) begin
                    state_d = ST_REQ;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            ST_REQ: begin
                if (wr_done) begin
                    if (!wr_nack) begin
                        retry_d = '0;
                        if (idx_q == LAST_IDX) begin
                            state_d = ST_DONE;
                        end else begin
                            idx_d   = idx_q + 4'd1;
                            state_d = ST_GAP;
                        end
                    end else begin
                        retry_d = retry_q + 1'b1;
                        state_d = (retry_q == RETRY_LAST) ? ST_ERR : ST_GAP;
                    end
                end
            end
            ST_GAP: begin
                state_d = ST_REQ;
            end
            ST_DONE, ST_ERR: begin
                if (start) begin
                    state_d = ST_WAIT;
                    cnt_d   = '0;
                    idx_d   = '0;
                    retry_d = '0;
                end
            end
            default: begin
                state_d = ST_WAIT;
            end
        endcase
    end

    // Outputs are decoded from the next state so they register in step with it.
    always_comb begin
        entry_d   = table_entry(idx_d);
        wr_req_d  = (state_d == ST_REQ);
        wr_dev_d  = wr_dev_q;
        wr_reg_d  = wr_reg_q;
        wr_data_d = wr_data_q;
        if (state_d == ST_REQ) begin
            wr_dev_d  = DEV_ADDR;
            wr_reg_d  = entry_d.reg_addr;
            wr_data_d = entry_d.data;
        end
        busy_d = (state_d == ST_WAIT) || (state_d == ST_REQ) || (state_d == ST_GAP);
        done_d = (state_d == ST_DONE);
        err_d  = (state_d == ST_ERR);
    end

    assign wr_req   = wr_req_q;
    assign wr_dev   = wr_dev_q;
    assign wr_reg   = wr_reg_q;
    assign wr_data  = wr_data_q;
    assign busy     = busy_q;
    assign cfg_done = done_q;
    assign cfg_err  = err_q;
    assign idx      = idx_q;

endmodule

// File: tb/tb_hdmi_cfg_seq.sv
// Directed bench for hdmi_cfg_seq: normal run, NACK retry, error and restart,
// mid-transaction reset, and ignored start/wr_done pulses.
module tb_hdmi_cfg_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       wr_done;
    logic       wr_nack;
    logic       wr_req;
    logic [7:0] wr_dev;
    logic [7:0] wr_reg;
    logic [7:0] wr_data;
    logic       busy;
    logic       cfg_done;
    logic       cfg_err;
    logic [3:0] idx;

    int checks = 0;
    int errors = 0;
    int issues9c = 0;
    int n;

    logic [15:0] expTable [10] = '{16'h4110, 16'h9803, 16'h9AE0, 16'h9C30, 16'h9D61,
                                   16'hA2A4, 16'hA3A4, 16'hE0D0, 16'hF900, 16'h1500};

    hdmi_cfg_seq #(
        .NUM_REGS   (10),
        .DEV_ADDR   (8'h72),
        .WAIT_CYCLES(16'd16),
        .MAX_RETRY  (3)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .wr_done (wr_done),
        .wr_nack (wr_nack),
        .wr_req  (wr_req),
        .wr_dev  (wr_dev),
        .wr_reg  (wr_reg),
        .wr_data (wr_data),
        .busy    (busy),
        .cfg_done(cfg_done),
        .cfg_err (cfg_err),
        .idx     (idx)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Counts edges until wr_req is seen high; a missing request is itself a failure.
    task automatic waitReq(output int cycles);
        cycles = 0;
        while (wr_req !== 1'b1 && cycles < 200) begin
            tick();
            cycles++;
        end
        if (wr_req !== 1'b1) checkOutput("req_timeout", {31'b0, wr_req}, 32'd1);
    endtask

    // Plays the byte engine for one transaction that is already requesting.
    task automatic applyStimulus(input int expIdx, input logic nack, input logic alsoStart);
        logic [15:0] e;
        e = expTable[expIdx];
        checkOutput($sformatf("idx_e%0d", expIdx), {28'b0, idx}, expIdx);
        checkOutput($sformatf("wr_reg_e%0d", expIdx), {24'b0, wr_reg}, {24'b0, e[15:8]});
        checkOutput($sformatf("wr_data_e%0d", expIdx), {24'b0, wr_data}, {24'b0, e[7:0]});
        checkOutput($sformatf("wr_dev_e%0d", expIdx), {24'b0, wr_dev}, 32'h72);
        if (wr_reg == 8'h9C) issues9c++;
        repeat (4) tick();
        checkOutput($sformatf("req_hold_e%0d", expIdx), {31'b0, wr_req}, 32'd1);
        checkOutput($sformatf("reg_hold_e%0d", expIdx), {24'b0, wr_reg}, {24'b0, e[15:8]});
        wr_done = 1'b1;
        wr_nack = nack;
        start   = alsoStart;
        tick();
        wr_done = 1'b0;
        wr_nack = 1'b0;
        start   = 1'b0;
    endtask

    // One entry plus what must follow it: either the final DONE or a single-cycle gap.
    task automatic stepEntry(input int i, input logic nack, input logic alsoStart, input logic spuriousGap);
        int c;
        applyStimulus(i, nack, alsoStart);
        if (!nack && i == 9) begin
            checkOutput("done_flag", {31'b0, cfg_done}, 32'd1);
            checkOutput("done_busy", {31'b0, busy}, 32'd0);
            checkOutput("done_err", {31'b0, cfg_err}, 32'd0);
            checkOutput("done_req", {31'b0, wr_req}, 32'd0);
            checkOutput("done_idx", {28'b0, idx}, 32'd9);
        end else begin
            checkOutput("gap_low", {31'b0, wr_req}, 32'd0);
            checkOutput("gap_busy", {31'b0, busy}, 32'd1);
            if (spuriousGap) begin
                wr_done = 1'b1;
                tick();
                wr_done = 1'b0;
                checkOutput("gap_spur_req", {31'b0, wr_req}, 32'd1);
            end else begin
                waitReq(c);
                checkOutput("gap_len", c, 32'd1);
            end
        end
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        rst     = 1'b0;
        start   = 1'b0;
        wr_done = 1'b0;
        wr_nack = 1'b0;
        repeat (3) tick();
        checkOutput("rst_req", {31'b0, wr_req}, 32'd0);
        checkOutput("rst_dev", {24'b0, wr_dev}, 32'd0);
        checkOutput("rst_reg", {24'b0, wr_reg}, 32'd0);
        checkOutput("rst_data", {24'b0, wr_data}, 32'd0);
        checkOutput("rst_busy", {31'b0, busy}, 32'd1);
        checkOutput("rst_done", {31'b0, cfg_done}, 32'd0);
        checkOutput("rst_err", {31'b0, cfg_err}, 32'd0);
        checkOutput("rst_idx", {28'b0, idx}, 32'd0);
        rst = 1'b1;

        // Run 1: normal, with ignored start/wr_done in WAIT, REQ and GAP.
        repeat (3) tick();
        wr_done = 1'b1;
        start   = 1'b1;
        tick();
        wr_done = 1'b0;
        start   = 1'b0;
        checkOutput("wait_spur_req", {31'b0, wr_req}, 32'd0);
        checkOutput("wait_spur_busy", {31'b0, busy}, 32'd1);
        checkOutput("wait_spur_idx", {28'b0, idx}, 32'd0);
        waitReq(n);
        checkOutput("wait_len_run1", n, 32'd12);
        for (int i = 0; i < 10; i++) begin
            if (i == 2) begin
                start = 1'b1;
                tick();
                start = 1'b0;
                checkOutput("req_spur_req", {31'b0, wr_req}, 32'd1);
                checkOutput("req_spur_idx", {28'b0, idx}, 32'd2);
                checkOutput("req_spur_reg", {24'b0, wr_reg}, 32'h9A);
            end
            stepEntry(i, 1'b0, (i == 9), (i == 4));
        end

        // Start that coincided with the final ack must not restart anything.
        repeat (3) tick();
        checkOutput("coinc_done", {31'b0, cfg_done}, 32'd1);
        checkOutput("coinc_busy", {31'b0, busy}, 32'd0);
        start = 1'b1;
        tick();
        start = 1'b0;
        checkOutput("restart_busy", {31'b0, busy}, 32'd1);
        checkOutput("restart_done", {31'b0, cfg_done}, 32'd0);
        checkOutput("restart_idx", {28'b0, idx}, 32'd0);
        waitReq(n);
        checkOutput("wait_len_run2", n, 32'd16);

        // Run 2: entry 3 NACKed twice before being accepted.
        issues9c = 0;
        for (int i = 0; i < 10; i++) begin
            if (i == 3) begin
                stepEntry(3, 1'b1, 1'b0, 1'b0);
                stepEntry(3, 1'b1, 1'b0, 1'b0);
            end
            stepEntry(i, 1'b0, 1'b0, 1'b0);
        end
        checkOutput("nack_9c_issues", issues9c, 32'd3);

        // Run 3: entry 0 NACKed until the retry budget runs out.
        start = 1'b1;
        tick();
        start = 1'b0;
        waitReq(n);
        checkOutput("wait_len_run3", n, 32'd16);
        stepEntry(0, 1'b1, 1'b0, 1'b0);
        stepEntry(0, 1'b1, 1'b0, 1'b0);
        applyStimulus(0, 1'b1, 1'b0);
        checkOutput("err_flag", {31'b0, cfg_err}, 32'd1);
        checkOutput("err_done", {31'b0, cfg_done}, 32'd0);
        checkOutput("err_idx", {28'b0, idx}, 32'd0);
        checkOutput("err_req", {31'b0, wr_req}, 32'd0);
        checkOutput("err_busy", {31'b0, busy}, 32'd0);
        start = 1'b1;
        tick();
        start = 1'b0;
        checkOutput("err_restart_busy", {31'b0, busy}, 32'd1);
        checkOutput("err_restart_err", {31'b0, cfg_err}, 32'd0);
        waitReq(n);
        checkOutput("wait_len_run4", n, 32'd16);

        // Run 4: reset pulled mid-transaction at entry 5.
        for (int i = 0; i < 5; i++) stepEntry(i, 1'b0, 1'b0, 1'b0);
        checkOutput("pre_rst_idx", {28'b0, idx}, 32'd5);
        checkOutput("pre_rst_req", {31'b0, wr_req}, 32'd1);
        #2;
        rst = 1'b0;
        #1;
        checkOutput("async_req", {31'b0, wr_req}, 32'd0);
        checkOutput("async_dev", {24'b0, wr_dev}, 32'd0);
        checkOutput("async_reg", {24'b0, wr_reg}, 32'd0);
        checkOutput("async_data", {24'b0, wr_data}, 32'd0);
        checkOutput("async_busy", {31'b0, busy}, 32'd1);
        checkOutput("async_done", {31'b0, cfg_done}, 32'd0);
        checkOutput("async_err", {31'b0, cfg_err}, 32'd0);
        checkOutput("async_idx", {28'b0, idx}, 32'd0);
        tick();
        tick();
        rst = 1'b1;
        waitReq(n);
        checkOutput("wait_len_after_rst", n, 32'd16);
        checkOutput("after_rst_reg", {24'b0, wr_reg}, 32'h41);
        checkOutput("after_rst_idx", {28'b0, idx}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
